matrix_bus_arbiter: RTL and testbench
=====================================

// Module: matrix_bus_arbiter
// PURPOSE
//  Two-master bus arbiter and slave decoder for the matrix subsystem bus.
//  M0 is the host/DMA master; M1 is the matrix master that writes operand words to 0x60-0x63.
//  Grants one master at a time, muxes its address/write/data onto the shared slave bus,
//  and decodes the address into a memory select or a matrix-register select.
//  Round-robin arbitration with a burst limit, so neither master starves.
// PARAMETERS
//  AW         8   address width
//  DW         32  data width
//  MAX_BURST  4   max consecutive granted cycles while the other master waits (>=1)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  M0_req       in   1   master 0 bus request
//  M0_wr        in   1   master 0 write strobe
//  M0_address   in   AW  master 0 address
//  M0_dout      in   DW  master 0 write data
//  M1_req       in   1   master 1 bus request
//  M1_wr        in   1   master 1 write strobe
//  M1_address   in   AW  master 1 address
//  M1_dout      in   DW  master 1 write data
//  M0_grant     out  1   master 0 owns the bus (registered)
//  M1_grant     out  1   master 1 owns the bus (registered)
//  S_address    out  AW  muxed address (0 when no grant)
//  S_wr         out  1   muxed write strobe (0 when no grant)
//  S_din        out  DW  muxed write data (0 when no grant)
//  S0_sel       out  1   memory select: grant active and S_address[7:5]==3'b000 (0x00-0x1F)
//  S1_sel       out  1   matrix select: grant active and S_address[7:4]==4'h6 (0x60-0x6F)
// BEHAVIOUR
//  - FSM states: IDLE (no grant), G0 (M0 owns the bus), G1 (M1 owns the bus).
//  - Grant outputs are decoded from the registered state. Mux and decode are combinational from the grant.
//  - Latency: a request sampled at edge n yields a grant after edge n, valid for cycle n+1.
//  - last_grant (1 bit) records the master most recently granted. Reset value 1, so M0 wins the first tie.
//  - IDLE transitions:
//      both requesting -> grant the master != last_grant
//      only Mx requesting -> Gx
//      no requests -> stay in IDLE
//  - Gx transitions:
//      Mx_req low, other requesting -> other grant, no idle cycle between grants
//      Mx_req low, other not requesting -> IDLE
//      Mx_req high, other requesting, burst_cnt==MAX_BURST-1 -> other grant (forced handover)
//      otherwise -> stay in Gx
//  - burst_cnt: clears on every grant change and on entry from IDLE.
//    Increments each cycle the grant is held; saturates at MAX_BURST-1.
//  - Grant is never granted to a master whose req is low. M0_grant and M1_grant are never both 1.
//  - Unmapped address: S0_sel=S1_sel=0. Bus fields are still driven; no error flag.
//  - Reset values (sync): state=IDLE, last_grant=1, burst_cnt=0.
//    All outputs are 0 in the cycle after reset is sampled.
//  - Reset asserted mid-burst: grant drops at the next edge regardless of req.
// TESTING
//  1 Reset held 2 cycles with M0_req=M1_req=1 -> all outputs 0.
//    Release -> M0_grant=1 one cycle later.
//  2 Only M1_req=1, M1_address=0x61, M1_wr=1, M1_dout=0xDEADBEEF ->
//    next cycle M1_grant=1, S_address=0x61, S_din=0xDEADBEEF, S1_sel=1, S0_sel=0.
//  3 Both req held high continuously, MAX_BURST=4 -> grants alternate in 4-cycle runs
//    (M0 x4, M1 x4, ...) with no idle gap.
//  4 M0 granted, M0_req drops while M1_req=0 -> IDLE next cycle with S_wr=0.
//    M1_req then rises -> M1_grant one cycle later.
//  5 M0 address 0x10 -> S0_sel=1. Address 0x40 -> S0_sel=S1_sel=0.
//  6 Reset pulsed during the 3rd cycle of an M1 burst -> M1_grant=0 next cycle.
//    After release, a tie is granted to M0.

Source files
------------

// File: rtl/matrix_bus_arbiter.sv
// Two-master round-robin bus arbiter with burst limit, shared-bus mux and slave decode
// for the matrix subsystem bus (memory at 0x00-0x1F, matrix registers at 0x60-0x6F).
module matrix_bus_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          M0_req,
  input  logic          M0_wr,
  input  logic [AW-1:0] M0_address,
  input  logic [DW-1:0] M0_dout,
  input  logic          M1_req,
  input  logic          M1_wr,
  input  logic [AW-1:0] M1_address,
  input  logic [DW-1:0] M1_dout,
  output logic          M0_grant,
  output logic          M1_grant,
  output logic [AW-1:0] S_address,
  output logic          S_wr,
  output logic [DW-1:0] S_din,
  output logic          S0_sel,
  output logic          S1_sel
);

  localparam int unsigned    BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          burst_done;
  logic          any_grant;

  assign burst_done = (burst_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (M0_req && M1_req) state_d = last_q ? G0 : G1;
        else if (M0_req)      state_d = G0;
        else if (M1_req)      state_d = G1;
      end
      G0: begin
        if (!M0_req)                 state_d = M1_req ? G1 : IDLE;
        else if (M1_req && burst_done) state_d = G1;
      end
      G1: begin
        if (!M1_req)                 state_d = M0_req ? G0 : IDLE;
        else if (M0_req && burst_done) state_d = G0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == G0)      last_d = 1'b0;
    else if (state_d == G1) last_d = 1'b1;
  end

  // Counter saturates so a long solo ownership hands over at once when the other master arrives.
  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE || state_d != state_q) burst_d = '0;
    else if (!burst_done)                      burst_d = burst_q + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign M0_grant  = (state_q == G0);
  assign M1_grant  = (state_q == G1);
  assign any_grant = M0_grant | M1_grant;

  always_comb begin
    S_address = '0;
    S_wr      = 1'b0;
    S_din     = '0;
    if (M0_grant) begin
      S_address = M0_address;
      S_wr      = M0_wr;
      S_din     = M0_dout;
    end else if (M1_grant) begin
      S_address = M1_address;
      S_wr      = M1_wr;
      S_din     = M1_dout;
    end
  end

  assign S0_sel = any_grant && (S_address[AW-1 -: 3] == 3'b000);
  assign S1_sel = any_grant && (S_address[AW-1 -: 4] == 4'h6);

endmodule

// File: tb/tb_matrix_bus_arbiter.sv
// Bench for matrix_bus_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_matrix_bus_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int OW = AW + DW + 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          M0_req, M0_wr, M1_req, M1_wr;
  logic [AW-1:0] M0_address, M1_address;
  logic [DW-1:0] M0_dout, M1_dout;
  logic          M0_grant, M1_grant, S_wr, S0_sel, S1_sel;
  logic [AW-1:0] S_address;
  logic [DW-1:0] S_din;
  logic [OW-1:0] obs;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: owner (-1 none, 0/1 master), last owner, cycles the current owner has held the bus.
  int m_owner = -1;
  int m_last  = 1;
  int m_held  = 0;

  matrix_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
    .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
    .M0_grant(M0_grant), .M1_grant(M1_grant),
    .S_address(S_address), .S_wr(S_wr), .S_din(S_din),
    .S0_sel(S0_sel), .S1_sel(S1_sel)
  );

  always #5 clk = ~clk;

  assign obs = {M0_grant, M1_grant, S_address, S_wr, S_din, S0_sel, S1_sel};

  always @(posedge clk) begin : ref_model
    int  nxt;
    logic mine, other;
    if (reset) begin
      m_owner <= -1;
      m_last  <= 1;
      m_held  <= 0;
    end else begin
      nxt = m_owner;
      if (m_owner < 0) begin
        if (M0_req && M1_req) nxt = 1 - m_last;
        else if (M0_req)      nxt = 0;
        else if (M1_req)      nxt = 1;
        else                  nxt = -1;
      end else begin
        mine  = (m_owner == 0) ? M0_req : M1_req;
        other = (m_owner == 0) ? M1_req : M0_req;
        if (!mine)                        nxt = other ? 1 - m_owner : -1;
        else if (other && m_held >= MB)   nxt = 1 - m_owner;
      end
      if (nxt >= 0 && nxt == m_owner) m_held <= m_held + 1;
      else                            m_held <= (nxt >= 0) ? 1 : 0;
      if (nxt >= 0) m_last <= nxt;
      m_owner <= nxt;
    end
  end

  function automatic logic [OW-1:0] expected();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w, s0, s1;
    a = '0; d = '0; w = 1'b0;
    if (m_owner == 0)      begin a = M0_address; d = M0_dout; w = M0_wr; end
    else if (m_owner == 1) begin a = M1_address; d = M1_dout; w = M1_wr; end
    s0 = (m_owner >= 0) && (a < 8'h20);
    s1 = (m_owner >= 0) && (a >= 8'h60) && (a <= 8'h6F);
    return {m_owner == 0, m_owner == 1, a, w, d, s0, s1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; M0_req = 1'b1; M1_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (obs !== '0) $display("FAIL reset_zero[%0d]: got %h required 0", i, obs);
      else pass_cnt++;
    end
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({M0_grant, M1_grant} !== 2'b10) $display("FAIL reset_release_tie: grants %b required 10", {M0_grant, M1_grant});
    else pass_cnt++;
    total_cnt++;
    if (obs !== expected()) $display("FAIL reset_release_model: got %h required %h", obs, expected());
    else pass_cnt++;
  endtask

  task automatic test_single_m1();
    M0_req = 1'b0; M1_req = 1'b1; M1_address = 8'h61; M1_wr = 1'b1; M1_dout = 32'hDEADBEEF;
    tick();
    total_cnt++;
    if ({M1_grant, S_address, S_din, S1_sel, S0_sel} !== {1'b1, 8'h61, 32'hDEADBEEF, 1'b1, 1'b0})
      $display("FAIL single_m1: got g=%b a=%h d=%h s1=%b s0=%b required g=1 a=61 d=deadbeef s1=1 s0=0",
               M1_grant, S_address, S_din, S1_sel, S0_sel);
    else pass_cnt++;
    total_cnt++;
    if (obs !== expected()) $display("FAIL single_m1_model: got %h required %h", obs, expected());
    else pass_cnt++;
  endtask

  task automatic test_burst();
    int prev, run, cur, runs;
    M0_req = 1'b0; M1_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; M0_req = 1'b1; M1_req = 1'b1;
    prev = -1; run = 0; runs = 0;
    for (int i = 0; i < 4 * MB + 1; i++) begin
      tick();
      total_cnt++;
      if ((M0_grant ^ M1_grant) !== 1'b1) $display("FAIL burst_no_gap[%0d]: grants %b required exactly one", i, {M0_grant, M1_grant});
      else pass_cnt++;
      total_cnt++;
      if (obs !== expected()) $display("FAIL burst_model[%0d]: got %h required %h", i, obs, expected());
      else pass_cnt++;
      cur = M1_grant ? 1 : 0;
      if (i == 0) begin
        total_cnt++;
        if (cur !== 0) $display("FAIL burst_first_owner: got M%0d required M0", cur);
        else pass_cnt++;
      end
      if (cur == prev) run++;
      else begin
        if (prev >= 0) begin
          total_cnt++;
          if (run !== MB) $display("FAIL burst_run_len[%0d]: got %0d required %0d", runs, run, MB);
          else pass_cnt++;
          runs++;
        end
        run = 1;
      end
      prev = cur;
    end
  endtask

  task automatic test_idle();
    M1_req = 1'b0; M0_req = 1'b1; M0_wr = 1'b1;
    for (int i = 0; i < 10 && !M0_grant; i++) tick();
    total_cnt++;
    if (M0_grant !== 1'b1) $display("FAIL idle_setup: M0_grant %b required 1", M0_grant);
    else pass_cnt++;
    M0_req = 1'b0;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL idle_drop: got %h required 0 (S_wr=%b)", obs, S_wr);
    else pass_cnt++;
    M1_req = 1'b1;
    tick();
    total_cnt++;
    if ({M0_grant, M1_grant} !== 2'b01) $display("FAIL idle_to_m1: grants %b required 01", {M0_grant, M1_grant});
    else pass_cnt++;
  endtask

  task automatic test_decode();
    logic [AW-1:0] addrs [6] = '{8'h10, 8'h40, 8'h1F, 8'h20, 8'h60, 8'h6F};
    logic [1:0]    sels  [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01};
    M1_req = 1'b0; M0_req = 1'b1; M0_address = addrs[0];
    tick();
    for (int i = 0; i < 6; i++) begin
      M0_address = addrs[i];
      #1;
      total_cnt++;
      if ({S0_sel, S1_sel} !== sels[i])
        $display("FAIL decode[%h]: sel %b required %b", addrs[i], {S0_sel, S1_sel}, sels[i]);
      else pass_cnt++;
      total_cnt++;
      if (obs !== expected()) $display("FAIL decode_model[%h]: got %h required %h", addrs[i], obs, expected());
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midburst();
    M0_req = 1'b0; M1_req = 1'b1;
    for (int i = 0; i < 10 && !M1_grant; i++) tick();
    tick();
    tick();
    total_cnt++;
    if (M1_grant !== 1'b1) $display("FAIL midburst_setup: M1_grant %b required 1", M1_grant);
    else pass_cnt++;
    reset = 1'b1; M0_req = 1'b1;
    tick();
    total_cnt++;
    if (obs !== '0) $display("FAIL midburst_reset: got %h required 0", obs);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({M0_grant, M1_grant} !== 2'b10) $display("FAIL midburst_tie: grants %b required 10", {M0_grant, M1_grant});
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      M0_req     = ($urandom_range(0, 3) != 0);
      M1_req     = ($urandom_range(0, 3) != 0);
      M0_wr      = $urandom_range(0, 1);
      M1_wr      = $urandom_range(0, 1);
      M0_address = $urandom_range(0, 2) == 0 ? 8'($urandom_range(8'h60, 8'h6F)) : 8'($urandom);
      M1_address = $urandom_range(0, 2) == 0 ? 8'($urandom_range(8'h00, 8'h1F)) : 8'($urandom);
      M0_dout    = $urandom;
      M1_dout    = $urandom;
      tick();
      total_cnt++;
      if (obs !== expected()) $display("FAIL random[%0d]: got %h required %h", i, obs, expected());
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    M0_req = 1'b0; M0_wr = 1'b0; M0_address = '0; M0_dout = '0;
    M1_req = 1'b0; M1_wr = 1'b0; M1_address = '0; M1_dout = '0;
    test_reset();
    test_single_m1();
    test_burst();
    test_idle();
    test_decode();
    test_reset_midburst();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
